// File: rtl/rd_req_sched_pkg.sv
// Shared encodings and AXI constants for the read-request scheduler.
package rd_req_sched_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned ID_W   = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [7:0] AXI_LEN4   = 8'd3;
  localparam logic [2:0] AXI_SIZE32 = 3'b010;
  localparam logic [1:0] AXI_INCR   = 2'b01;

  localparam logic [ADDR_W-1:0] LINE_MASK = 32'hFFFF_FFF0;

  // Align a byte address down to its 16-byte line.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return a & LINE_MASK;
  endfunction

endpackage

// File: rtl/rd_req_sched_arb.sv
// Round-robin one-hot arbiter: first request at/after ptr, circularly.
module rr_arb_onehot #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan from ptr upward, wrapping, and keep the first hit.
  always_comb begin
    logic [IW-1:0] j;
    j     = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = IW'((32'(ptr) + k) % NREQ);
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = j;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rd_req_sched.sv
// Shares one AXI read path between NREQ requesters, one 4-beat burst at a time.
module rd_req_sched
  import rd_req_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter logic [3:0]  ID_BASE = 4'd0,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_addr,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [LINE_W-1:0]    rsp_data,
  output logic                 rsp_err,
  input  logic [NREQ-1:0]      rsp_full,
  output logic                 arvalid,
  input  logic                 arready,
  output logic [ADDR_W-1:0]    araddr,
  output logic [ID_W-1:0]      arid,
  output logic [7:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic                 next_rrq,
  output logic [ID_W-1:0]      next_rid,
  output logic                 rqfull_1,
  input  logic [LINE_W-1:0]    rdat_m_data,
  input  logic                 finish_mrd
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     owner_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [TW-1:0]     timer_q;
  logic [LINE_W-1:0] line_q;
  logic              err_q;

  logic [NREQ-1:0]   grant_c;
  logic [IW-1:0]     gidx_c;
  logic              gany_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic              owner_full_c;
  logic              take_c;
  logic              done_ok_c;
  logic              done_to_c;
  logic              send_c;

  rr_arb_onehot #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant_c),
    .idx   (gidx_c),
    .any   (gany_c)
  );

  assign sel_addr_c   = req_addr[32*gidx_c +: 32];
  assign owner_full_c = rsp_full[owner_q];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle strobes.
  always_comb begin
    state_d   = state_q;
    take_c    = 1'b0;
    done_ok_c = 1'b0;
    done_to_c = 1'b0;
    send_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gany_c) begin
          take_c  = 1'b1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (arready) state_d = S_DATA;
      end
      S_DATA: begin
        // A finish landing on the last timer cycle still returns data.
        if (finish_mrd) begin
          done_ok_c = 1'b1;
          state_d   = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          done_to_c = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (!owner_full_c) begin
          send_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, AR channel, timer and line buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= '0;
      rr_ptr_q <= '0;
      timer_q  <= '0;
      line_q   <= '0;
      err_q    <= 1'b0;
      arvalid  <= 1'b0;
      araddr   <= '0;
      arid     <= '0;
      next_rrq <= 1'b0;
      next_rid <= '0;
    end else begin
      next_rrq <= take_c;
      if (take_c) begin
        owner_q  <= gidx_c;
        rr_ptr_q <= (gidx_c == IW'(NREQ - 1)) ? '0 : IW'(gidx_c + 1'b1);
        araddr   <= line_addr(sel_addr_c);
        arid     <= ID_BASE + 4'(gidx_c);
        next_rid <= ID_BASE + 4'(gidx_c);
        arvalid  <= 1'b1;
      end else if (state_q == S_ADDR && arready) begin
        arvalid  <= 1'b0;
      end
      if (state_q == S_ADDR)      timer_q <= '0;
      else if (state_q == S_DATA) timer_q <= TW'(timer_q + 1'b1);
      if (done_ok_c) begin
        line_q <= rdat_m_data;
        err_q  <= 1'b0;
      end else if (done_to_c) begin
        line_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

  assign req_ready = take_c ? grant_c : '0;
  assign rsp_valid = send_c ? (NREQ'(1) << owner_q) : '0;
  assign rsp_data  = line_q;
  assign rsp_err   = err_q;
  assign rqfull_1  = (state_q != S_IDLE) && owner_full_c;
  assign arlen     = AXI_LEN4;
  assign arsize    = AXI_SIZE32;
  assign arburst   = AXI_INCR;

endmodule
